// File: rtl/iir_coef_update_ctrl.sv
// Coefficient update sequencer for the IIR biquad core.
// The host fills six shadow registers (b0, b1, b2, a0, a1, a2) and then commits.
// On the next sample boundary the controller streams the full set to the core
// over a valid/ready bus, so the core never runs a sample on a mixed set.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | accepts host writes and commits (cmd_ready=1)
// WAIT_BND | commit accepted, waiting for the next sample_boundary pulse
// LOAD     | presenting coefficient word idx, advancing on each handshake
// DONE     | one-cycle upd_done pulse, then back to IDLE
module iir_coef_update_ctrl #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH_P-1:0] cmd_addr,
    input  logic [DATA_WIDTH_P-1:0] cmd_data,
    input  logic                    cmd_commit,
    input  logic                    sample_boundary,
    output logic                    coef_valid,
    input  logic                    coef_ready,
    output logic [ADDR_WIDTH_P-1:0] coef_addr,
    output logic [DATA_WIDTH_P-1:0] coef_data,
    output logic                    upd_busy,
    output logic                    upd_done,
    output logic                    addr_err
);

    localparam logic [ADDR_WIDTH_P-1:0] ADDR_B0    = ADDR_WIDTH_P'(16'h0038);
    localparam logic [ADDR_WIDTH_P-1:0] ADDR_B1    = ADDR_WIDTH_P'(16'h0040);
    localparam logic [ADDR_WIDTH_P-1:0] ADDR_B2    = ADDR_WIDTH_P'(16'h0048);
    localparam logic [ADDR_WIDTH_P-1:0] ADDR_A0    = ADDR_WIDTH_P'(16'h0050);
    localparam logic [ADDR_WIDTH_P-1:0] ADDR_A1    = ADDR_WIDTH_P'(16'h0058);
    localparam logic [ADDR_WIDTH_P-1:0] ADDR_A2    = ADDR_WIDTH_P'(16'h0060);
    localparam logic [ADDR_WIDTH_P-1:0] ADDR_LIMIT = ADDR_WIDTH_P'(16'h0068);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        LOAD     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                  state;
    logic [2:0]              idx;
    logic [2:0]              idx_nxt;
    logic [2:0]              sel;
    logic                    host_xfer;
    logic [ADDR_WIDTH_P-1:0] nxt_addr;
    logic [DATA_WIDTH_P-1:0] nxt_data;
    logic [DATA_WIDTH_P-1:0] shadow [6];

    assign cmd_ready = (state == IDLE) && rst_n;
    assign host_xfer = cmd_valid && cmd_ready;
    assign idx_nxt   = idx + 3'd1;
    // Entering LOAD always starts at word 0; inside LOAD we prefetch the next word.
    assign sel       = (state == LOAD) ? idx_nxt : 3'd0;

    // Select the word to be presented after the next register update.
    always_comb begin
        nxt_addr = ADDR_B0;
        nxt_data = shadow[0];
        case (sel)
            3'd0: begin nxt_addr = ADDR_B0; nxt_data = shadow[0]; end
            3'd1: begin nxt_addr = ADDR_B1; nxt_data = shadow[1]; end
            3'd2: begin nxt_addr = ADDR_B2; nxt_data = shadow[2]; end
            3'd3: begin nxt_addr = ADDR_A0; nxt_data = shadow[3]; end
            3'd4: begin nxt_addr = ADDR_A1; nxt_data = shadow[4]; end
            3'd5: begin nxt_addr = ADDR_A2; nxt_data = shadow[5]; end
            default: begin nxt_addr = ADDR_B0; nxt_data = shadow[0]; end
        endcase
    end

    // Shadow register file; only writable in IDLE since host_xfer needs cmd_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
        end else if (host_xfer && !cmd_commit) begin
            case (cmd_addr)
                ADDR_B0: shadow[0] <= cmd_data;
                ADDR_B1: shadow[1] <= cmd_data;
                ADDR_B2: shadow[2] <= cmd_data;
                ADDR_A0: shadow[3] <= cmd_data;
                ADDR_A1: shadow[4] <= cmd_data;
                ADDR_A2: shadow[5] <= cmd_data;
                default: ;
            endcase
        end
    end

    // Update sequencer with registered coefficient bus and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            coef_valid <= 1'b0;
            coef_addr  <= '0;
            coef_data  <= '0;
            upd_busy   <= 1'b0;
            upd_done   <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            upd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_xfer) begin
                        if (cmd_commit) begin
                            state    <= WAIT_BND;
                            upd_busy <= 1'b1;
                        end else if (cmd_addr >= ADDR_LIMIT) begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                WAIT_BND: begin
                    if (sample_boundary) begin
                        state      <= LOAD;
                        idx        <= 3'd0;
                        coef_valid <= 1'b1;
                        coef_addr  <= nxt_addr;
                        coef_data  <= nxt_data;
                    end
                end
                LOAD: begin
                    if (coef_ready) begin
                        if (idx == 3'd5) begin
                            state      <= DONE;
                            coef_valid <= 1'b0;
                            upd_busy   <= 1'b0;
                            upd_done   <= 1'b1;
                        end else begin
                            idx       <= idx_nxt;
                            coef_addr <= nxt_addr;
                            coef_data <= nxt_data;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_coef_update_ctrl.sv
// Self-checking bench for iir_coef_update_ctrl.
// A model of the shadow registers is kept here; each commit pushes the six
// expected words onto a queue that is popped on every coefficient handshake.
`timescale 1ns/1ps
module tb_iir_coef_update_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } coef_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          cmd_commit;
    logic          sample_boundary;
    logic          coef_valid;
    logic          coef_ready;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_data;
    logic          upd_busy;
    logic          upd_done;
    logic          addr_err;

    coef_t         exp_q[$];
    logic [DW-1:0] model [6];
    int            tests;
    int            fails;

    iir_coef_update_ctrl #(.DATA_WIDTH_P(DW), .ADDR_WIDTH_P(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .cmd_commit      (cmd_commit),
        .sample_boundary (sample_boundary),
        .coef_valid      (coef_valid),
        .coef_ready      (coef_ready),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .upd_busy        (upd_busy),
        .upd_done        (upd_done),
        .addr_err        (addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [AW-1:0] slot_addr(input int i);
        return AW'(16'h0038 + 8 * i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_commit = 1'b0; cmd_addr = a; cmd_data = d;
        while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL write_accept addr=%h: cmd_ready=%b required 1", a, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) if (a == slot_addr(i)) model[i] = d;
    endtask

    task automatic host_commit(input bit with_bnd);
        coef_t e;
        int    n;
        n = 0;
        cmd_valid = 1'b1; cmd_commit = 1'b1; sample_boundary = with_bnd;
        while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL commit_accept: cmd_ready=%b required 1", cmd_ready);
        end
        for (int i = 0; i < 6; i++) begin
            e.addr = slot_addr(i);
            e.data = model[i];
            exp_q.push_back(e);
        end
        tick();
        cmd_valid = 1'b0; cmd_commit = 1'b0; sample_boundary = 1'b0;
        tests++;
        if (upd_busy !== 1'b1) begin
            fails++;
            $display("FAIL commit_busy: upd_busy=%b required 1", upd_busy);
        end
    endtask

    // Runs one update from the cycle after commit acceptance. The boundary is
    // pulsed bnd_delay cycles later; optionally coef_ready toggles and a b0=0xFF
    // write is held pending on the host port until it is accepted.
    task automatic run_load(input int bnd_delay, input bit toggle, input bit hold_write,
                            output int busy_cnt, output int done_cnt);
        coef_t         e;
        int            hs;
        bit            held;
        bit            after_done;
        bit            done_now;
        bit            accept;
        bit            accepted;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        busy_cnt = 0; done_cnt = 0; hs = 0; held = 0; after_done = 0; accepted = 0;
        h_addr = '0; h_data = '0;
        if (hold_write) begin
            cmd_valid = 1'b1; cmd_commit = 1'b0; cmd_addr = 16'h0038; cmd_data = 32'h0000_00FF;
        end
        for (int c = 0; c < bnd_delay + 24; c++) begin
            sample_boundary = (c == bnd_delay);
            coef_ready = toggle ? (c % 2 == 0) : 1'b1;
            accept = 0;
            if (upd_busy === 1'b1) busy_cnt++;
            done_now = (upd_done === 1'b1);
            if (done_now) done_cnt++;
            if (c <= bnd_delay) begin
                tests++;
                if (coef_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL early_valid c=%0d: coef_valid=%b required 0", c, coef_valid);
                end
            end
            if (held) begin
                tests++;
                if (coef_addr !== h_addr || coef_data !== h_data) begin
                    fails++;
                    $display("FAIL hold_stable: addr=%h data=%h required addr=%h data=%h",
                             coef_addr, coef_data, h_addr, h_data);
                end
            end
            held = (coef_valid === 1'b1) && !coef_ready;
            h_addr = coef_addr; h_data = coef_data;
            if (coef_valid === 1'b1 && coef_ready) begin
                hs++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_word: addr=%h data=%h with nothing expected", coef_addr, coef_data);
                end else begin
                    e = exp_q.pop_front();
                    if (coef_addr !== e.addr || coef_data !== e.data) begin
                        fails++;
                        $display("FAIL coef_word %0d: addr=%h data=%h required addr=%h data=%h",
                                 hs, coef_addr, coef_data, e.addr, e.data);
                    end
                end
            end
            if (hold_write && cmd_valid) begin
                tests++;
                if (cmd_ready !== after_done) begin
                    fails++;
                    $display("FAIL busy_ready c=%0d: cmd_ready=%b required %b", c, cmd_ready, after_done);
                end
                accept = after_done && (cmd_ready === 1'b1);
            end
            tick();
            if (accept) begin
                cmd_valid = 1'b0;
                model[0] = 32'h0000_00FF;
                accepted = 1;
            end
            if (done_now) after_done = 1;
        end
        sample_boundary = 1'b0; coef_ready = 1'b0; cmd_valid = 1'b0;
        tests++;
        if (hs != 6) begin
            fails++;
            $display("FAIL handshakes: got %0d required 6", hs);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL words_left: %0d words never sent, required 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL done_pulses: got %0d required 1", done_cnt);
        end
        if (hold_write) begin
            tests++;
            if (!accepted) begin
                fails++;
                $display("FAIL held_write: accepted=%0d required 1", accepted);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        tests++;
        if (coef_valid !== 1'b0 || upd_busy !== 1'b0 || upd_done !== 1'b0 ||
            addr_err !== 1'b0 || cmd_ready !== 1'b0 || coef_addr !== '0 || coef_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b err=%b ready=%b addr=%h data=%h required all 0",
                     coef_valid, upd_busy, upd_done, addr_err, cmd_ready, coef_addr, coef_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) model[i] = '0;
        tick();
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int busy, done;
        for (int i = 0; i < 6; i++) host_write(slot_addr(i), DW'(32'h11 * (i + 1)));
        host_commit(1'b0);
        run_load(3, 1'b0, 1'b0, busy, done);
        tests++;
        if (busy != 10) begin
            fails++;
            $display("FAIL basic_busy_len: got %0d cycles required 10", busy);
        end
    endtask

    task automatic test_addr_decode();
        int busy, done;
        logic [AW-1:0] addrs [4];
        logic          errs  [4];
        addrs[0] = 16'h0000; errs[0] = 1'b0;
        addrs[1] = 16'h0068; errs[1] = 1'b1;
        addrs[2] = 16'h0044; errs[2] = 1'b0;
        addrs[3] = 16'hFFFF; errs[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            host_write(addrs[k], 32'hDEAD_0000 + k);
            tests++;
            if (addr_err !== errs[k]) begin
                fails++;
                $display("FAIL addr_err addr=%h: got %b required %b", addrs[k], addr_err, errs[k]);
            end
            tick();
            tests++;
            if (addr_err !== 1'b0) begin
                fails++;
                $display("FAIL addr_err_width addr=%h: got %b required 0", addrs[k], addr_err);
            end
        end
        host_commit(1'b0);
        run_load(0, 1'b0, 1'b0, busy, done);
    endtask

    task automatic test_backpressure();
        int busy, done;
        for (int i = 0; i < 6; i++) host_write(slot_addr(i), 32'hA5A5_0000 + i);
        host_commit(1'b0);
        run_load(1, 1'b1, 1'b0, busy, done);
    endtask

    task automatic test_boundary_gating();
        int busy, done;
        host_commit(1'b1);
        run_load(20, 1'b0, 1'b0, busy, done);
        tests++;
        if (busy != 27) begin
            fails++;
            $display("FAIL gating_busy_len: got %0d cycles required 27", busy);
        end
    endtask

    task automatic test_busy_blocking();
        int busy, done;
        host_write(16'h0038, 32'h0000_0B00);
        host_commit(1'b0);
        run_load(2, 1'b0, 1'b1, busy, done);
        host_commit(1'b0);
        run_load(0, 1'b0, 1'b0, busy, done);
        tests++;
        if (busy != 7) begin
            fails++;
            $display("FAIL min_latency_busy: got %0d cycles required 7", busy);
        end
    endtask

    task automatic test_back_to_back();
        int busy, done;
        host_commit(1'b0);
        run_load(0, 1'b0, 1'b0, busy, done);
        host_commit(1'b0);
        run_load(0, 1'b1, 1'b0, busy, done);
    endtask

    task automatic test_reset_mid_load();
        int    busy, done;
        coef_t e;
        for (int i = 0; i < 6; i++) host_write(slot_addr(i), 32'h0000_0100 + i);
        host_commit(1'b0);
        sample_boundary = 1'b1; coef_ready = 1'b1;
        tick();
        sample_boundary = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            tests++;
            if (coef_valid !== 1'b1 || coef_addr !== e.addr || coef_data !== e.data) begin
                fails++;
                $display("FAIL mid_word %0d: valid=%b addr=%h data=%h required 1 %h %h",
                         k, coef_valid, coef_addr, coef_data, e.addr, e.data);
            end
            tick();
        end
        tests++;
        if (coef_valid !== 1'b1 || coef_addr !== slot_addr(3)) begin
            fails++;
            $display("FAIL mid_index3: valid=%b addr=%h required 1 %h", coef_valid, coef_addr, slot_addr(3));
        end
        coef_ready = 1'b0; rst_n = 1'b0;
        tick(); tick();
        tests++;
        if (coef_valid !== 1'b0 || upd_busy !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b busy=%b ready=%b required 0 0 0", coef_valid, upd_busy, cmd_ready);
        end
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) model[i] = '0;
        for (int k = 0; k < 5; k++) begin
            sample_boundary = (k == 2); coef_ready = 1'b1;
            tests++;
            if (coef_valid !== 1'b0 || upd_busy !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_quiet k=%0d: valid=%b busy=%b required 0 0", k, coef_valid, upd_busy);
            end
            tick();
        end
        sample_boundary = 1'b0; coef_ready = 1'b0;
        host_commit(1'b0);
        run_load(1, 1'b0, 1'b0, busy, done);
        tests++;
        if (busy != 8) begin
            fails++;
            $display("FAIL post_reset_busy: got %0d cycles required 8", busy);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_commit = 1'b0; cmd_addr = '0; cmd_data = '0;
        sample_boundary = 1'b0; coef_ready = 1'b0;
        for (int i = 0; i < 6; i++) model[i] = '0;
        test_reset();
        test_basic();
        test_addr_decode();
        test_backpressure();
        test_boundary_gating();
        test_busy_blocking();
        test_back_to_back();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
